countdown_alarm: RTL and testbench
==================================

Name: countdown_alarm

Overview:
- Downstream stage of the two-digit countdown timer. Consumes its BCD digits and run enable, and drives the two 7-segment displays.
- When an armed countdown reaches 00: flashes the displays and sounds a buzzer for a fixed time or until acknowledged, then holds a steady "done" indication.
- Contains its own segment decoding, so it replaces the direct digit-to-decoder path.

Parameters:
- TICK_DIV, 50000000: clock cycles per one-second alarm tick.
- FLASH_DIV, 12500000: clock cycles per flash half-period.
- ALARM_SECS, 10: alarm duration in seconds before auto-stop.
- TONE_DIV, 25000: clock cycles per buzzer tone half-period (used only with the optional feature).

Ports:
- clock, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- digit_ones, input, 4: BCD ones digit from the counter; values 10-15 mean blank.
- digit_tens, input, 4: BCD tens digit from the counter; values 10-15 mean blank.
- running, input, 1: counter run enable; 1 = counting.
- ack_n, input, 1: raw active-low acknowledge pushbutton.
- l1, output, 7: ones display segments, active-low.
- l2, output, 7: tens display segments, active-low.
- buzzer, output, 1: buzzer drive.
- alarm_active, output, 1: high while in ALARM.
- done_led, output, 1: high while in DONE.

Behaviour:
- Reset (asynchronous, reset=0):
  - State IDLE; all counters 0; flash_phase=1.
  - l1 = l2 = 7'b1111111; buzzer, alarm_active and done_led all 0.
- Decode, bits {a..g}, 0 = segment lit:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001101, 8=0000000, 9=0000100
  - any value 10 or above = 1111111.
- Segment outputs are registered: 1 clock of latency from the digit inputs.
- Definitions:
  - valid: both digits < 10.
  - zero: valid and both digits == 0.
- ack_n path: 2-flop synchronizer, then falling-edge detect giving a 1-cycle ack_pulse. A held button produces only one pulse.
- FSM, evaluated each clock, listed in priority order:
  - IDLE:
    - running=1 and valid and not zero -> ARMED.
    - Otherwise stay.
    - Displays show the decoded digits.
  - ARMED:
    - zero -> ALARM (checked first, regardless of running).
    - Else not valid -> IDLE.
    - Else stay. Pause (running=0) does not disarm.
    - Displays show the decoded digits.
  - ALARM:
    - Entry clears the flash and second counters and sets flash_phase=1.
    - flash_phase toggles every FLASH_DIV cycles.
    - The second counter increments every TICK_DIV cycles.
    - When the second count reaches ALARM_SECS, or on ack_pulse -> DONE. If both occur in the same cycle -> DONE once.
    - Digits changing while in ALARM are ignored for state, but the displays show the current decoded digits when flash_phase=1 and 1111111 when flash_phase=0.
    - alarm_active=1; buzzer per the optional feature.
  - DONE:
    - done_led=1; buzzer=0; displays show the decoded digits steadily.
    - valid and not zero (a new value has been loaded) -> IDLE.
    - Otherwise stay, including while blanked.
- alarm_active, done_led and buzzer are registered, and change in the same cycle as the state register.
- Counter widths must hold TICK_DIV-1, FLASH_DIV-1 and ALARM_SECS without overflow. Counters wrap to 0 at the terminal count.
- Reset mid-alarm stops the buzzer immediately (asynchronously) and returns to IDLE.

Optional Feature:
- Macro: COUNTDOWN_ALARM_TONE_EN.
- Defined: buzzer = tone & flash_phase during ALARM.
  - tone is a square wave toggling every TONE_DIV cycles, cleared on ALARM entry.
  - This suits a passive piezo.
- Undefined: buzzer = flash_phase during ALARM, for an active buzzer. No tone counter is present and TONE_DIV is unused.
- In both cases buzzer=0 outside ALARM.

Test Plan:
All scenarios use TICK_DIV=10, FLASH_DIV=4, ALARM_SECS=3, TONE_DIV=2.
1. Reset: reset=0 with digits 05 -> l1=l2=1111111, all other outputs 0. Release reset -> l1=0100100 (5), l2=0000001 (0) one cycle later, state IDLE.
2. Arm and fire: running=1, digits 02 -> ARMED. Digits step 01 then 00 -> alarm_active=1 the cycle after 00 is seen. Displays alternate 0000001 and 1111111 every 4 cycles, starting lit.
3. Timeout: remain in ALARM with no ack -> after 30 cycles alarm_active=0, done_led=1, buzzer=0, displays steady 0000001. Load digits 07 -> IDLE, done_led=0.
4. Acknowledge: mid-ALARM, drive ack_n low for 20 cycles -> DONE within 4 cycles of the falling edge (2 synchronizer cycles + 1 edge-detect cycle + 1 state register). The held button causes no further effect. ack_n pulse while in IDLE -> no state change.
5. Pause and invalid digits: in ARMED with running=0 at digits 03 -> stays ARMED. Digits become blank (10) -> IDLE, displays 1111111. Digits return to 03 with running=1 -> ARMED.
6. Reset during ALARM: assert reset -> buzzer and alarm_active go 0 without waiting for a clock edge. After release -> IDLE; a held 00 does not re-arm.

Source files
------------

// File: rtl/countdown_alarm.sv
// countdown_alarm: downstream stage of the two-digit countdown timer.
// It watches the BCD digits and the run enable, and raises an alarm when an
// armed countdown reaches 00. During the alarm the displays flash and the
// buzzer sounds, until a fixed timeout or an acknowledge. After that it holds
// a steady "done" indication until a new non-zero value is loaded.
//
// Ports:
//   clock         system clock
//   reset         asynchronous, active-low reset
//   digit_ones    BCD ones digit (10-15 = blank)
//   digit_tens    BCD tens digit (10-15 = blank)
//   running       counter run enable
//   ack_n         raw active-low acknowledge pushbutton
//   l1, l2        ones / tens 7-segment outputs {a..g}, active-low, registered
//   buzzer        buzzer drive
//   alarm_active  high while in ALARM
//   done_led      high while in DONE
//
// Optional feature macro: COUNTDOWN_ALARM_TONE_EN
//   defined   -> buzzer = tone & flash_phase in ALARM (passive piezo)
//   undefined -> buzzer = flash_phase in ALARM (active buzzer), TONE_DIV unused
//
// state | meaning
// IDLE  | not armed, displays show digits
// ARMED | non-zero value seen while running, waiting for 00
// ALARM | flashing displays + buzzer, until timeout or ack
// DONE  | steady done indication until a new non-zero value is loaded
module countdown_alarm #(
  parameter int TICK_DIV   = 50000000,
  parameter int FLASH_DIV  = 12500000,
  parameter int ALARM_SECS = 10,
  parameter int TONE_DIV   = 25000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] digit_ones,
  input  logic [3:0] digit_tens,
  input  logic       running,
  input  logic       ack_n,
  output logic [6:0] l1,
  output logic [6:0] l2,
  output logic       buzzer,
  output logic       alarm_active,
  output logic       done_led
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int FW = $clog2(FLASH_DIV + 1);
  localparam int SW = $clog2(ALARM_SECS + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);
  localparam logic [SW-1:0] SEC_LAST   = SW'(ALARM_SECS - 1);
  localparam logic [6:0]    SEG_BLANK  = 7'b1111111;

  typedef enum logic [1:0] {IDLE, ARMED, ALARM, DONE} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tick_cnt, tick_nxt;
  logic [FW-1:0] flash_cnt, flash_nxt;
  logic [SW-1:0] sec_cnt, sec_nxt;
  logic          flash_phase, phase_nxt;
  logic          ack_s1, ack_s2, ack_prev, ack_pulse;
  logic          valid, zero, tick_done, flash_done, sec_hit, blank;
  logic [6:0]    l1_nxt, l2_nxt;
  logic          buzzer_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001101;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  // Button idles high, so the synchronizer resets to 1 to avoid a false edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ack_s1    <= 1'b1;
      ack_s2    <= 1'b1;
      ack_prev  <= 1'b1;
      ack_pulse <= 1'b0;
    end else begin
      ack_s1    <= ack_n;
      ack_s2    <= ack_s1;
      ack_prev  <= ack_s2;
      ack_pulse <= ack_prev & ~ack_s2;
    end
  end

  assign valid      = (digit_ones < 4'd10) && (digit_tens < 4'd10);
  assign zero       = valid && (digit_ones == 4'd0) && (digit_tens == 4'd0);
  assign tick_done  = (tick_cnt == TICK_LAST);
  assign flash_done = (flash_cnt == FLASH_LAST);
  // Leave on the tick that would make the second count reach ALARM_SECS.
  assign sec_hit    = tick_done && (sec_cnt == SEC_LAST);

`ifdef COUNTDOWN_ALARM_TONE_EN
  localparam int NW = $clog2(TONE_DIV + 1);
  localparam logic [NW-1:0] TONE_LAST = NW'(TONE_DIV - 1);
  logic [NW-1:0] tone_cnt, tone_cnt_nxt;
  logic          tone, tone_nxt;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (running && valid && !zero) state_nxt = ARMED;
      ARMED:   if (zero) state_nxt = ALARM;
               else if (!valid) state_nxt = IDLE;
      ALARM:   if (ack_pulse || sec_hit) state_nxt = DONE;
      DONE:    if (valid && !zero) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Alarm timers run only while staying in ALARM; any other case (including
  // entry) leaves them cleared with the displays in the lit phase.
  always_comb begin
    tick_nxt  = '0;
    flash_nxt = '0;
    sec_nxt   = '0;
    phase_nxt = 1'b1;
`ifdef COUNTDOWN_ALARM_TONE_EN
    tone_cnt_nxt = '0;
    tone_nxt     = 1'b0;
`endif
    if (state == ALARM && state_nxt == ALARM) begin
      tick_nxt  = tick_done ? '0 : tick_cnt + 1'b1;
      sec_nxt   = tick_done ? sec_cnt + 1'b1 : sec_cnt;
      flash_nxt = flash_done ? '0 : flash_cnt + 1'b1;
      phase_nxt = flash_done ? ~flash_phase : flash_phase;
`ifdef COUNTDOWN_ALARM_TONE_EN
      tone_cnt_nxt = (tone_cnt == TONE_LAST) ? '0 : tone_cnt + 1'b1;
      tone_nxt     = (tone_cnt == TONE_LAST) ? ~tone : tone;
`endif
    end
  end

  always_comb begin
    blank  = (state_nxt == ALARM) && !phase_nxt;
    l1_nxt = blank ? SEG_BLANK : seg_decode(digit_ones);
    l2_nxt = blank ? SEG_BLANK : seg_decode(digit_tens);
`ifdef COUNTDOWN_ALARM_TONE_EN
    buzzer_nxt = (state_nxt == ALARM) && phase_nxt && tone_nxt;
`else
    buzzer_nxt = (state_nxt == ALARM) && phase_nxt;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      flash_cnt    <= '0;
      sec_cnt      <= '0;
      flash_phase  <= 1'b1;
      l1           <= SEG_BLANK;
      l2           <= SEG_BLANK;
      buzzer       <= 1'b0;
      alarm_active <= 1'b0;
      done_led     <= 1'b0;
    end else begin
      state        <= state_nxt;
      tick_cnt     <= tick_nxt;
      flash_cnt    <= flash_nxt;
      sec_cnt      <= sec_nxt;
      flash_phase  <= phase_nxt;
      l1           <= l1_nxt;
      l2           <= l2_nxt;
      buzzer       <= buzzer_nxt;
      alarm_active <= (state_nxt == ALARM);
      done_led     <= (state_nxt == DONE);
    end
  end

`ifdef COUNTDOWN_ALARM_TONE_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tone_cnt <= '0;
      tone     <= 1'b0;
    end else begin
      tone_cnt <= tone_cnt_nxt;
      tone     <= tone_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_countdown_alarm.sv
module tb_countdown_alarm;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] digit_ones, digit_tens;
  logic       running, ack_n;
  logic [6:0] l1, l2;
  logic       buzzer, alarm_active, done_led;

  int total = 0;
  int bad   = 0;
  int n;

  localparam logic [6:0] S0 = 7'b0000001, S2 = 7'b0010010, S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100, S5 = 7'b0100100, S7 = 7'b0001101;
  localparam logic [6:0] BL = 7'b1111111;

  countdown_alarm #(
    .TICK_DIV(10), .FLASH_DIV(4), .ALARM_SECS(3), .TONE_DIV(2)
  ) dut (
    .clock(clock), .reset(reset), .digit_ones(digit_ones), .digit_tens(digit_tens),
    .running(running), .ack_n(ack_n), .l1(l1), .l2(l2), .buzzer(buzzer),
    .alarm_active(alarm_active), .done_led(done_led)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask

  task automatic set_digits(input logic [3:0] t, input logic [3:0] o);
    digit_tens = t;
    digit_ones = o;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset
    reset = 1'b0; running = 1'b0; ack_n = 1'b1; set_digits(4'd0, 4'd5);
    #22;
    check("rst_l1", l1, BL);
    check("rst_l2", l2, BL);
    check("rst_buz", buzzer, 0);
    check("rst_alarm", alarm_active, 0);
    check("rst_done", done_led, 0);
    @(posedge clock); #1 reset = 1'b1;
    cyc(1);
    check("idle_l1", l1, S5);
    check("idle_l2", l2, S0);

    // 2. arm and fire
    running = 1'b1; set_digits(4'd0, 4'd2);
    cyc(1);
    check("arm_l1", l1, S2);
    set_digits(4'd0, 4'd1); cyc(1);
    check("arm_alarm_off", alarm_active, 0);
    set_digits(4'd0, 4'd0); cyc(1);          // E0 + 1
    check("fire_alarm", alarm_active, 1);
    check("fire_l1_lit", l1, S0);
    check("fire_l2_lit", l2, S0);
`ifndef COUNTDOWN_ALARM_TONE_EN
    check("fire_buz", buzzer, 1);
`endif
    cyc(3);                                  // E3 + 1
    check("flash_lit_end", l1, S0);
    cyc(1);                                  // E4 + 1
    check("flash_blank_l1", l1, BL);
    check("flash_blank_l2", l2, BL);
    check("flash_blank_buz", buzzer, 0);
    cyc(3);                                  // E7 + 1
    check("flash_blank_end", l1, BL);
    cyc(1);                                  // E8 + 1
    check("flash_relit", l1, S0);

    // 3. timeout after 30 cycles in ALARM
    cyc(21);                                 // E29 + 1
    check("to_still_alarm", alarm_active, 1);
    cyc(1);                                  // E30 + 1
    check("to_alarm_off", alarm_active, 0);
    check("to_done", done_led, 1);
    check("to_buz", buzzer, 0);
    check("to_l1", l1, S0);
    check("to_l2", l2, S0);
    cyc(5);
    check("done_steady", l1, S0);
    check("done_hold", done_led, 1);
    set_digits(4'd0, 4'd7); cyc(1);
    check("reload_done", done_led, 0);
    check("reload_l1", l1, S7);

    // 4. acknowledge
    cyc(1);                                  // IDLE -> ARMED
    set_digits(4'd0, 4'd0); cyc(1);
    check("ack_fire", alarm_active, 1);
    cyc(5);
    ack_n = 1'b0;
    n = 0;
    while (!done_led && n < 8) begin
      cyc(1);
      n++;
    end
    check("ack_latency_ok", (n >= 1 && n <= 4), 1);
    check("ack_alarm_off", alarm_active, 0);
    cyc(10);
    check("ack_held_done", done_led, 1);
    check("ack_held_alarm", alarm_active, 0);
    ack_n = 1'b1; cyc(3);
    running = 1'b0; set_digits(4'd0, 4'd4); cyc(1);
    check("ack_to_idle", done_led, 0);
    check("ack_idle_l1", l1, S4);
    ack_n = 1'b0; cyc(3); ack_n = 1'b1; cyc(5);
    check("idle_ack_done", done_led, 0);
    check("idle_ack_alarm", alarm_active, 0);

    // 5. pause and invalid digits
    running = 1'b1; set_digits(4'd0, 4'd3); cyc(1);   // ARMED
    running = 1'b0; cyc(5);
    set_digits(4'd10, 4'd10); cyc(1);                 // -> IDLE
    check("blank_l1", l1, BL);
    check("blank_l2", l2, BL);
    set_digits(4'd0, 4'd3); cyc(1);
    set_digits(4'd0, 4'd0); cyc(2);                   // IDLE ignores 00
    check("blank_disarmed", alarm_active, 0);
    set_digits(4'd0, 4'd3); running = 1'b1; cyc(1);   // ARMED
    check("rearm_l1", l1, S3);
    running = 1'b0; cyc(4);                           // pause keeps ARMED
    set_digits(4'd0, 4'd0); cyc(1);
    check("pause_fire", alarm_active, 1);

    // 6. reset during ALARM
    cyc(1);
`ifndef COUNTDOWN_ALARM_TONE_EN
    check("pre_rst_buz", buzzer, 1);
`endif
    #2 reset = 1'b0;
    #1;
    check("async_buz", buzzer, 0);
    check("async_alarm", alarm_active, 0);
    check("async_l1", l1, BL);
    #3 reset = 1'b1;
    running = 1'b1;
    cyc(5);
    check("post_rst_alarm", alarm_active, 0);
    check("post_rst_l1", l1, S0);
    check("post_rst_done", done_led, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
